// File: rtl/core_pkg.sv
// core_pkg: shared types and inst bit positions
// for the attention-core sequencer.
package core_pkg;

    typedef enum logic [3:0] {
        IDLE,
        QWR,
        KWR,
        KLD,
        KWAIT,
        EXEC,
        DRAIN,
        NORM,
        DONE
    } state_t;

    typedef enum logic [1:0] {
        N0,
        N1,
        N2,
        N3
    } phase_t;

    localparam int I_FIFO_EXT = 19;
    localparam int I_DIV      = 18;
    localparam int I_ACC      = 17;
    localparam int I_OFIFO_RD = 16;
    localparam int I_QK_LSB   = 12;
    localparam int I_PM_LSB   = 8;
    localparam int I_EXEC     = 7;
    localparam int I_LOAD     = 6;
    localparam int I_QMEM_RD  = 5;
    localparam int I_QMEM_WR  = 4;
    localparam int I_KMEM_RD  = 3;
    localparam int I_KMEM_WR  = 2;
    localparam int I_PMEM_RD  = 1;
    localparam int I_PMEM_WR  = 0;

endpackage

// File: rtl/core_seq.sv
// core_seq: drives inst/wr_norm of the attention core through one
// Q.K^T pass; fields appear one cycle after the state selecting them.
module core_seq
    import core_pkg::*;
#(
    parameter int col        = 8,
    parameter int pr         = 16,
    parameter int load_drain = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [4:0]  nq,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        fifo_valid,
    output logic [19:0] inst,
    output logic        wr_norm,
    output logic        busy,
    output logic        done
);

    localparam logic [4:0] NQ_MAX   = 5'(pr);
    localparam logic [4:0] COL_LAST = 5'(col - 1);
    localparam logic [4:0] LD_LAST  = 5'(load_drain - 1);

    state_t      state_q, state_d;
    phase_t      phase_q, phase_d;
    logic [4:0]  nq_q, nq_d;
    logic [4:0]  i_q, i_d, j_q, j_d, r_q, r_d;
    logic        pend_q, pend_d;
    logic [19:0] inst_d;
    logic        wn_d, done_d;
    logic        accept;
    logic [4:0]  nq_last;

    assign accept  = in_valid & in_ready;
    assign nq_last = nq_q - 5'd1;

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        nq_d    = nq_q;
        i_d     = i_q;
        j_d     = j_q;
        r_d     = r_q;
        pend_d  = 1'b0;
        inst_d  = '0;
        wn_d    = 1'b0;
        done_d  = 1'b0;
        inst_d[I_FIFO_EXT] = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    nq_d = (nq == 5'd0 || nq > NQ_MAX) ? NQ_MAX : nq;
                    i_d     = '0;
                    j_d     = '0;
                    r_d     = '0;
                    phase_d = N0;
                    state_d = QWR;
                end
            end
            QWR: begin
                if (accept) begin
                    inst_d[I_QMEM_WR]       = 1'b1;
                    inst_d[I_QK_LSB +: 4]   = i_q[3:0];
                    if (i_q == nq_last) begin
                        i_d     = '0;
                        state_d = KWR;
                    end else begin
                        i_d = i_q + 5'd1;
                    end
                end
            end
            KWR: begin
                if (accept) begin
                    inst_d[I_KMEM_WR]       = 1'b1;
                    inst_d[I_QK_LSB +: 4]   = i_q[3:0];
                    if (i_q == COL_LAST) begin
                        i_d     = '0;
                        state_d = KLD;
                    end else begin
                        i_d = i_q + 5'd1;
                    end
                end
            end
            KLD: begin
                inst_d[I_KMEM_RD]     = 1'b1;
                inst_d[I_LOAD]        = 1'b1;
                inst_d[I_QK_LSB +: 4] = i_q[3:0];
                if (i_q == COL_LAST) begin
                    i_d     = '0;
                    state_d = KWAIT;
                end else begin
                    i_d = i_q + 5'd1;
                end
            end
            KWAIT: begin
                if (i_q == LD_LAST) begin
                    i_d     = '0;
                    state_d = EXEC;
                end else begin
                    i_d = i_q + 5'd1;
                end
            end
            EXEC: begin
                inst_d[I_QMEM_RD]     = 1'b1;
                inst_d[I_EXEC]        = 1'b1;
                inst_d[I_QK_LSB +: 4] = i_q[3:0];
                if (i_q == nq_last) begin
                    i_d     = '0;
                    state_d = DRAIN;
                end else begin
                    i_d = i_q + 5'd1;
                end
            end
            DRAIN: begin
                // i counts issued fifo reads, j the PSUM writes trailing them
                if (fifo_valid && i_q != nq_q) begin
                    inst_d[I_OFIFO_RD] = 1'b1;
                    i_d    = i_q + 5'd1;
                    pend_d = 1'b1;
                end
                if (pend_q) begin
                    inst_d[I_PMEM_WR]     = 1'b1;
                    inst_d[I_PM_LSB +: 4] = j_q[3:0];
                    j_d = j_q + 5'd1;
                    if (j_q == nq_last) begin
                        state_d = NORM;
                    end
                end
            end
            NORM: begin
                unique case (phase_q)
                    N0: begin
                        inst_d[I_PMEM_RD]     = 1'b1;
                        inst_d[I_PM_LSB +: 4] = r_q[3:0];
                        phase_d = N1;
                    end
                    N1: begin
                        inst_d[I_ACC] = 1'b1;
                        phase_d = N2;
                    end
                    N2: begin
                        inst_d[I_DIV] = 1'b1;
                        phase_d = N3;
                    end
                    N3: begin
                        inst_d[I_PMEM_WR]     = 1'b1;
                        inst_d[I_PM_LSB +: 4] = r_q[3:0];
                        wn_d    = 1'b1;
                        phase_d = N0;
                        if (r_q == nq_last) begin
                            state_d = DONE;
                        end else begin
                            r_d = r_q + 5'd1;
                        end
                    end
                endcase
            end
            DONE: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            phase_q  <= N0;
            nq_q     <= '0;
            i_q      <= '0;
            j_q      <= '0;
            r_q      <= '0;
            pend_q   <= 1'b0;
            inst     <= '0;
            wr_norm  <= 1'b0;
            in_ready <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            nq_q     <= nq_d;
            i_q      <= i_d;
            j_q      <= j_d;
            r_q      <= r_d;
            pend_q   <= pend_d;
            inst     <= inst_d;
            wr_norm  <= wn_d;
            in_ready <= (state_d == QWR) || (state_d == KWR);
            busy     <= (state_d != IDLE);
            done     <= done_d;
        end
    end

endmodule

// File: tb/tb_core_seq.sv
// tb_core_seq: table of full passes checked against an event
// scoreboard of expected nonzero inst/wr_norm/done words.
module tb_core_seq;

    localparam int COL = 8;
    localparam int LD  = 8;
    localparam int B_DIV = 18, B_ACC = 17, B_ORD = 16, B_EXE = 7;
    localparam int B_LD  = 6,  B_QRD = 5,  B_QWR = 4,  B_KRD = 3;
    localparam int B_KWR = 2,  B_PRD = 1,  B_PWR = 0;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [4:0]  nq;
    logic        in_valid;
    logic        in_ready;
    logic        fifo_valid;
    logic [19:0] inst;
    logic        wr_norm;
    logic        busy;
    logic        done;

    always #5 clk = ~clk;

    core_seq #(.col(COL), .pr(16), .load_drain(LD)) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .nq(nq),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .fifo_valid(fifo_valid),
        .inst(inst),
        .wr_norm(wr_norm),
        .busy(busy),
        .done(done)
    );

    typedef struct {
        string      name;
        logic [4:0] nq_in;
        bit         toggle;
        int         stall;
        bit         restart;
        int         exp_nq;
        int         exp_cyc;
    } vec_t;

    vec_t        tbl[8];
    logic [21:0] exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    bit          mon_en   = 1'b0;
    logic        fv_at_edge = 1'b0;

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, got, want);
        end
    endtask

    task automatic push(input logic d, input logic wn, input logic [19:0] w);
        exp_q.push_back({d, wn, w});
    endtask

    task automatic build(input int n);
        logic [19:0] w;
        exp_q.delete();
        for (int a = 0; a < n; a++) begin
            w = '0; w[B_QWR] = 1'b1; w[15:12] = 4'(a);
            push(1'b0, 1'b0, w);
        end
        for (int a = 0; a < COL; a++) begin
            w = '0; w[B_KWR] = 1'b1; w[15:12] = 4'(a);
            push(1'b0, 1'b0, w);
        end
        for (int a = 0; a < COL; a++) begin
            w = '0; w[B_KRD] = 1'b1; w[B_LD] = 1'b1; w[15:12] = 4'(a);
            push(1'b0, 1'b0, w);
        end
        for (int a = 0; a < n; a++) begin
            w = '0; w[B_QRD] = 1'b1; w[B_EXE] = 1'b1; w[15:12] = 4'(a);
            push(1'b0, 1'b0, w);
        end
        w = '0; w[B_ORD] = 1'b1;
        push(1'b0, 1'b0, w);
        for (int k = 1; k < n; k++) begin
            w = '0; w[B_ORD] = 1'b1; w[B_PWR] = 1'b1; w[11:8] = 4'(k - 1);
            push(1'b0, 1'b0, w);
        end
        w = '0; w[B_PWR] = 1'b1; w[11:8] = 4'(n - 1);
        push(1'b0, 1'b0, w);
        for (int r = 0; r < n; r++) begin
            w = '0; w[B_PRD] = 1'b1; w[11:8] = 4'(r);
            push(1'b0, 1'b0, w);
            w = '0; w[B_ACC] = 1'b1;
            push(1'b0, 1'b0, w);
            w = '0; w[B_DIV] = 1'b1;
            push(1'b0, 1'b0, w);
            w = '0; w[B_PWR] = 1'b1; w[11:8] = 4'(r);
            push(1'b0, 1'b1, w);
        end
        push(1'b1, 1'b0, 20'h0);
    endtask

    always @(posedge clk) fv_at_edge <= fifo_valid;

    always @(negedge clk) begin
        if (mon_en) begin
            chk("fifo_ext_rd_low", 32'(inst[19]), 32'd0);
            if (inst[B_ORD]) chk("ofifo_rd_needs_valid", 32'(fv_at_edge), 32'd1);
            if (inst != 20'h0 || wr_norm || done) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_event: got %h expected none",
                             {done, wr_norm, inst});
                end else begin
                    chk("event", 32'({done, wr_norm, inst}), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    task automatic run_pass(input vec_t v);
        int cyc;
        int stall_left;
        bit seen_exec;
        bit got_done;
        build(v.exp_nq);
        mon_en = 1'b1;
        @(negedge clk);
        nq         = v.nq_in;
        start      = 1'b1;
        in_valid   = 1'b1;
        fifo_valid = (v.stall == 0);
        cyc        = 0;
        stall_left = v.stall;
        seen_exec  = 1'b0;
        got_done   = 1'b0;
        while (!got_done && cyc < 3000) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            start = (v.restart && cyc == 30);
            if (cyc == 1) chk({v.name, "_busy"}, 32'(busy), 32'd1);
            if (done) got_done = 1'b1;
            if (v.toggle) in_valid = ~in_valid;
            if (inst[B_EXE]) begin
                seen_exec = 1'b1;
            end else if (seen_exec) begin
                if (stall_left > 0) stall_left--;
                else fifo_valid = 1'b1;
            end
        end
        start = 1'b0;
        chk({v.name, "_done_seen"}, 32'(got_done), 32'd1);
        if (!got_done) begin
            mon_en = 1'b0;
            reset  = 1'b0;
            @(negedge clk);
            reset  = 1'b1;
        end else if (v.exp_cyc != 0) begin
            chk({v.name, "_cycles"}, 32'(cyc + 1), 32'(v.exp_cyc));
        end
        in_valid   = 1'b0;
        fifo_valid = 1'b0;
        repeat (8) @(negedge clk);
        chk({v.name, "_idle_busy"}, 32'(busy), 32'd0);
        chk({v.name, "_idle_ready"}, 32'(in_ready), 32'd0);
        chk({v.name, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        bit found;
        tbl[0] = '{"nq4_hold",    5'd4,  1'b0, 0, 1'b0, 4,  56};
        tbl[1] = '{"nq4_toggle",  5'd4,  1'b1, 0, 1'b0, 4,  0};
        tbl[2] = '{"nq4_stall",   5'd4,  1'b0, 5, 1'b0, 4,  0};
        tbl[3] = '{"nq2_norm",    5'd2,  1'b0, 0, 1'b0, 2,  42};
        tbl[4] = '{"nq0_restart", 5'd0,  1'b0, 0, 1'b1, 16, 140};
        tbl[5] = '{"nq20_clamp",  5'd20, 1'b0, 0, 1'b0, 16, 140};
        tbl[6] = '{"nq1_mixed",   5'd1,  1'b1, 3, 1'b0, 1,  0};
        tbl[7] = '{"nq16_full",   5'd16, 1'b0, 0, 1'b0, 16, 140};

        reset      = 1'b0;
        start      = 1'b0;
        nq         = 5'd0;
        in_valid   = 1'b0;
        fifo_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_inst", 32'(inst), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd0);
        chk("rst_wr_norm", 32'(wr_norm), 32'd0);
        reset = 1'b1;
        @(negedge clk);

        nq       = 5'd4;
        start    = 1'b1;
        in_valid = 1'b1;
        @(negedge clk);
        start = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 200 && !found; k++) begin
            @(negedge clk);
            if (inst[B_LD]) found = 1'b1;
        end
        chk("kld_reached", 32'(found), 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("midrst_inst", 32'(inst), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        @(negedge clk);
        reset    = 1'b1;
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("midrst_stays_idle", 32'(busy), 32'd0);

        for (int t = 0; t < 8; t++) run_pass(tbl[t]);

        mon_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
